conv_peak_detect: RTL and testbench
===================================

# conv_peak_detect

Downstream consumer of the convolution stage. It collects one frame of 2*LENGTH-1 signed 16-bit convolution results and reduces it to a peak value, the peak's index and the frame sum. The reduced result is presented through a single-entry valid/ready output slot to the next stage, e.g. a decision or reporting block.

## Interface
- LENGTH, 8: convolution length; frame = 2*LENGTH-1 samples (15 at default); legal range 2..128
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high
- in_valid  in  1  in_data carries a convolution result this cycle
- in_first  in  1  qualifies in_valid; marks sample index 0 of a frame
- in_data  in  16  signed two's-complement result sample
- out_valid  out  1  output slot holds a result; reset 0
- out_ready  in  1  downstream accepts the slot when out_valid && out_ready
- out_peak  out  16  signed peak sample value; reset 0
- out_index  out  8  index 0..2*LENGTH-2 of the peak within the frame; reset 0
- out_sum  out  24  signed sum of all frame samples, sign-extended; reset 0
- frame_err  out  1  one-cycle pulse on a framing violation; reset 0
- overflow  out  1  sticky; a completed frame was dropped; cleared only by reset; reset 0

## Operation
- Accumulators: cnt (8b), acc_peak (16b), acc_idx (8b), acc_sum (24b). States: IDLE, COLLECT.
- IDLE, in_valid && in_first: acc_peak=in_data, acc_idx=0, acc_sum=sext(in_data), cnt=1. Go to COLLECT.
- IDLE, in_valid && !in_first: sample ignored; frame_err pulses.
- COLLECT, in_valid && !in_first:
  - acc_sum += sext(in_data).
  - If in_data beats acc_peak: acc_peak=in_data, acc_idx=cnt.
  - cnt += 1.
- "Beats" means strictly greater, so on ties the earliest index wins.
- COLLECT, in_valid && in_first (premature start):
  - frame_err pulses.
  - The partial frame is discarded.
  - Accumulators restart with this sample as index 0. Stay in COLLECT.
- Completion: the sample accepted with cnt == 2*LENGTH-2 is the last of the frame.
  - Its contribution is included in the result.
  - The final peak, index and sum load the output slot.
  - State returns to IDLE; cnt clears.
- Output slot:
  - If the slot is empty, or is being accepted in the same cycle, the completed result loads and out_valid=1.
  - Otherwise the new result is dropped and overflow is set. The held result is unchanged.
- out_valid clears on the edge after out_valid && out_ready, unless a new result loads on that same edge.
- Outputs are stable while out_valid && !out_ready.
- Sum width: 16b + log2(255) fits in 24b, so no saturation is needed. out_sum is exact.

## Timing
- Last sample accepted at edge T: out_valid=1 with the results from edge T onward, i.e. visible in cycle T+1.
- Latency from last sample to output: 1 cycle.
- Throughput: one sample per cycle. Back-to-back frames are allowed, so in_first may follow the last sample immediately.
- frame_err is registered and high for exactly the cycle after the offending sample.
- Reset mid-frame:
  - The partial frame is lost.
  - out_valid, frame_err and overflow go to 0.
  - The state machine goes to IDLE on the reset edge.
  - The first in_first after reset deasserts starts a new frame.
- Simultaneous completion and acceptance: the new result replaces the old one, out_valid stays 1, and overflow is not set.
- in_valid=0 cycles inside a frame are holes. No state changes; the frame resumes on the next valid.

## Configuration
- CONV_PEAK_ABS_EN defined: "beats" compares magnitudes.
  - Magnitudes use a 17-bit compare, so |-32768| = 32768 is the largest.
  - out_peak still reports the original signed sample.
- CONV_PEAK_ABS_EN undefined: plain signed compare.

## Test plan
- Ramp frame 1..15 (LENGTH=8), out_ready=1 -> out_valid pulse 1 cycle after the last sample; peak=15, index=14, sum=120.
- All -5 except index 7 = -1 -> peak=-1, index=7, sum=-71. Ties: 50 at indices 2 and 10, others 0 -> index=2, sum=100.
- -300 at index 3, 200 at index 9, others 0 -> without CONV_PEAK_ABS_EN: peak=200, index=9; with it: peak=-300, index=3; sum=-100 in both builds.
- out_ready=0, two ramp frames back-to-back -> first result held unchanged and overflow=1 after the second completes. Raise out_ready -> out_valid falls the next cycle.
- in_first asserted again at sample 6, then a full 15-sample frame of value 7 -> frame_err pulse; result peak=7, index=0, sum=105. A stray in_valid in IDLE also pulses frame_err with no result.
- reset for 1 cycle at sample 9 of a frame, then a clean ramp frame -> all outputs 0 during/after reset; the next result is peak=15, index=14, sum=120 with overflow=0.

Source files
------------

// File: rtl/conv_peak_detect_if.sv
// conv_peak_detect_if: sample stream in, reduced frame result out.
// The master modport is the side that feeds samples and consumes results.
// The slave modport is the peak detector itself.
interface conv_peak_detect_if;
  logic        in_valid;
  logic        in_first;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_peak;
  logic [7:0]  out_index;
  logic [23:0] out_sum;
  logic        frame_err;
  logic        overflow;

  modport master (
    output in_valid, in_first, in_data, out_ready,
    input  out_valid, out_peak, out_index, out_sum, frame_err, overflow
  );

  modport slave (
    input  in_valid, in_first, in_data, out_ready,
    output out_valid, out_peak, out_index, out_sum, frame_err, overflow
  );
endinterface

// File: rtl/conv_peak_detect.sv
// conv_peak_detect: reduces one frame of 2*LENGTH-1 signed convolution
// results to its peak value, the peak's index and the frame sum, and offers
// the result through a single-entry valid/ready slot.
// Optional feature: define CONV_PEAK_ABS_EN to pick the peak by magnitude
// instead of by signed value (the reported peak keeps its sign).
module conv_peak_detect #(
  parameter int LENGTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  conv_peak_detect_if.slave   bus
);

  localparam logic [7:0] LAST_IDX = 8'(2 * LENGTH - 2);

  typedef enum logic [0:0] {
    IDLE,
    COLLECT
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic signed [15:0] accPeak_q, accPeak_d;
  logic [7:0]         accIdx_q, accIdx_d;
  logic signed [23:0] accSum_q, accSum_d;

  logic               outValid_q, outValid_d;
  logic signed [15:0] outPeak_q, outPeak_d;
  logic [7:0]         outIndex_q, outIndex_d;
  logic signed [23:0] outSum_q, outSum_d;
  logic               frameErr_q, frameErr_d;
  logic               overflow_q, overflow_d;

  logic               frameDone;
  logic signed [23:0] sampleSext;

`ifdef CONV_PEAK_ABS_EN
  // 17 bits so that |-32768| is representable and ranks above everything
  function automatic logic [16:0] magnitude(input logic signed [15:0] v);
    logic [16:0] ext;
    ext = {v[15], v};
    return v[15] ? (~ext + 17'd1) : ext;
  endfunction

  function automatic logic beats(input logic signed [15:0] a,
                                 input logic signed [15:0] b);
    return magnitude(a) > magnitude(b);
  endfunction
`else
  function automatic logic beats(input logic signed [15:0] a,
                                 input logic signed [15:0] b);
    return a > b;
  endfunction
`endif

  assign sampleSext = {{8{bus.in_data[15]}}, bus.in_data};

  // Next-state logic: frame accumulation, framing errors and output slot
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accPeak_d  = accPeak_q;
    accIdx_d   = accIdx_q;
    accSum_d   = accSum_q;
    outValid_d = outValid_q;
    outPeak_d  = outPeak_q;
    outIndex_d = outIndex_q;
    outSum_d   = outSum_q;
    frameErr_d = 1'b0;
    overflow_d = overflow_q;
    frameDone  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_first) begin
            accPeak_d = bus.in_data;
            accIdx_d  = 8'd0;
            accSum_d  = sampleSext;
            cnt_d     = 8'd1;
            state_d   = COLLECT;
          end else begin
            frameErr_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (bus.in_valid) begin
          if (bus.in_first) begin
            frameErr_d = 1'b1;
            accPeak_d  = bus.in_data;
            accIdx_d   = 8'd0;
            accSum_d   = sampleSext;
            cnt_d      = 8'd1;
          end else begin
            accSum_d = accSum_q + sampleSext;
            if (beats(bus.in_data, accPeak_q)) begin
              accPeak_d = bus.in_data;
              accIdx_d  = cnt_q;
            end
            if (cnt_q == LAST_IDX) begin
              frameDone = 1'b1;
              cnt_d     = 8'd0;
              state_d   = IDLE;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A finished frame may only replace a result that is absent or leaving now
    if (frameDone) begin
      if (!outValid_q || bus.out_ready) begin
        outValid_d = 1'b1;
        outPeak_d  = accPeak_d;
        outIndex_d = accIdx_d;
        outSum_d   = accSum_d;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      accPeak_q  <= 16'sd0;
      accIdx_q   <= 8'd0;
      accSum_q   <= 24'sd0;
      outValid_q <= 1'b0;
      outPeak_q  <= 16'sd0;
      outIndex_q <= 8'd0;
      outSum_q   <= 24'sd0;
      frameErr_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      accPeak_q  <= accPeak_d;
      accIdx_q   <= accIdx_d;
      accSum_q   <= accSum_d;
      outValid_q <= outValid_d;
      outPeak_q  <= outPeak_d;
      outIndex_q <= outIndex_d;
      outSum_q   <= outSum_d;
      frameErr_q <= frameErr_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_peak  = outPeak_q;
  assign bus.out_index = outIndex_q;
  assign bus.out_sum   = outSum_q;
  assign bus.frame_err = frameErr_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_conv_peak_detect.sv
// tb_conv_peak_detect: directed frames against a frame-level reference model,
// plus literal expectations for the documented example frames.
module tb_conv_peak_detect;

  localparam int L = 8;
  localparam int N = 2 * L - 1;

  logic clk = 1'b0;
  logic reset;

  // Free-running clock
  always #5 clk = ~clk;

  conv_peak_detect_if bus();

  conv_peak_detect #(.LENGTH(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 1'b0;

  // Reference model state: samples of the open frame and the expected outputs
  int fq[$];
  bit mValid;
  int mPeak, mIdx, mSum;
  bit mErr, mOvf;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int absI(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit beats(input int a, input int b);
`ifdef CONV_PEAK_ABS_EN
    return absI(a) > absI(b);
`else
    return a > b;
`endif
  endfunction

  task automatic modelClear();
    fq.delete();
    mValid = 1'b0;
    mPeak  = 0;
    mIdx   = 0;
    mSum   = 0;
    mErr   = 1'b0;
    mOvf   = 1'b0;
  endtask

  // Reduce a whole frame at once, then decide what the output slot does
  task automatic modelStep();
    bit accepted;
    bit done;
    int d, pk, ix, sm;
    accepted = mValid && bus.out_ready;
    done = 1'b0;
    mErr = 1'b0;
    pk = 0; ix = 0; sm = 0;
    if (bus.in_valid) begin
      d = int'($signed(bus.in_data));
      if (bus.in_first) begin
        if (fq.size() > 0) mErr = 1'b1;
        fq.delete();
        fq.push_back(d);
      end else if (fq.size() == 0) begin
        mErr = 1'b1;
      end else begin
        fq.push_back(d);
        if (fq.size() == N) begin
          done = 1'b1;
          pk = fq[0];
          for (int i = 0; i < N; i++) begin
            sm += fq[i];
            if (beats(fq[i], pk)) begin
              pk = fq[i];
              ix = i;
            end
          end
          fq.delete();
        end
      end
    end
    if (done) begin
      if (!mValid || bus.out_ready) begin
        mValid = 1'b1;
        mPeak  = pk;
        mIdx   = ix;
        mSum   = sm;
      end else begin
        mOvf = 1'b1;
      end
    end else if (accepted) begin
      mValid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit v, input bit f, input int d);
    bus.in_valid = v;
    bus.in_first = f;
    bus.in_data  = 16'(d);
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic resetDut();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_data  = 16'd0;
    @(posedge clk);
    modelClear();
    #1;
    reset = 1'b0;
  endtask

  task automatic sendFrame(input int vals[0:N-1], input int holeAt);
    for (int i = 0; i < N; i++) begin
      if (i == holeAt) begin
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0);
      end
      applyStimulus(1'b1, i == 0, vals[i]);
    end
  endtask

  task automatic checkResult(input string tag, input int peak, input int idx, input int sum);
    checkOutput({tag, "_valid"}, int'(bus.out_valid), 1);
    checkOutput({tag, "_peak"}, int'($signed(bus.out_peak)), peak);
    checkOutput({tag, "_index"}, int'(bus.out_index), idx);
    checkOutput({tag, "_sum"}, int'($signed(bus.out_sum)), sum);
  endtask

  // Every cycle, compare the DUT against the reference model
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("out_valid", int'(bus.out_valid), int'(mValid));
      if (mValid) begin
        checkOutput("out_peak", int'($signed(bus.out_peak)), mPeak);
        checkOutput("out_index", int'(bus.out_index), mIdx);
        checkOutput("out_sum", int'($signed(bus.out_sum)), mSum);
      end
      checkOutput("frame_err", int'(bus.frame_err), int'(mErr));
      checkOutput("overflow", int'(bus.overflow), int'(mOvf));
    end
  end

  // Directed scenarios
  initial begin
    int vals[0:N-1];
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_data   = 16'd0;
    bus.out_ready = 1'b1;
    modelClear();
    resetDut();
    checkEn = 1'b1;

    checkOutput("rst_valid", int'(bus.out_valid), 0);
    checkOutput("rst_peak", int'(bus.out_peak), 0);
    checkOutput("rst_index", int'(bus.out_index), 0);
    checkOutput("rst_sum", int'(bus.out_sum), 0);
    checkOutput("rst_err", int'(bus.frame_err), 0);
    checkOutput("rst_ovf", int'(bus.overflow), 0);

    for (int i = 0; i < N; i++) vals[i] = i + 1;
    sendFrame(vals, -1);
    checkResult("ramp", 15, 14, 120);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("ramp_pulse_end", int'(bus.out_valid), 0);

    for (int i = 0; i < N; i++) vals[i] = -5;
    vals[7] = -1;
    sendFrame(vals, -1);
    checkResult("neg", -1, 7, -71);

    for (int i = 0; i < N; i++) vals[i] = 0;
    vals[2]  = 50;
    vals[10] = 50;
    sendFrame(vals, 6);
    checkResult("tie", 50, 2, 100);

    for (int i = 0; i < N; i++) vals[i] = 0;
    vals[3] = -300;
    vals[9] = 200;
    sendFrame(vals, -1);
`ifdef CONV_PEAK_ABS_EN
    checkResult("mag", -300, 3, -100);
`else
    checkResult("mag", 200, 9, -100);
`endif
    applyStimulus(1'b0, 1'b0, 0);

    // Completion on the same edge the held result is accepted
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) vals[i] = i + 1;
    sendFrame(vals, -1);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) bus.out_ready = 1'b1;
      applyStimulus(1'b1, i == 0, 7);
    end
    checkResult("swap", 7, 0, 105);
    checkOutput("swap_ovf", int'(bus.overflow), 0);
    applyStimulus(1'b0, 1'b0, 0);

    // Overflow: second frame completes while the first is still held
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) vals[i] = i + 1;
    sendFrame(vals, -1);
    for (int i = 0; i < N; i++) vals[i] = 3;
    sendFrame(vals, -1);
    checkResult("held", 15, 14, 120);
    checkOutput("held_ovf", int'(bus.overflow), 1);
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("drain_valid", int'(bus.out_valid), 0);
    checkOutput("drain_ovf", int'(bus.overflow), 1);

    // Premature in_first at sample 6 restarts the frame
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, i == 0, 100 + i);
    applyStimulus(1'b1, 1'b1, 7);
    checkOutput("premature_err", int'(bus.frame_err), 1);
    for (int i = 1; i < N; i++) applyStimulus(1'b1, 1'b0, 7);
    checkResult("restart", 7, 0, 105);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 99);
    checkOutput("stray_err", int'(bus.frame_err), 1);
    checkOutput("stray_valid", int'(bus.out_valid), 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("stray_err_end", int'(bus.frame_err), 0);

    // Reset in the middle of a frame
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, i == 0, i + 1);
    resetDut();
    checkOutput("mid_rst_valid", int'(bus.out_valid), 0);
    checkOutput("mid_rst_peak", int'(bus.out_peak), 0);
    checkOutput("mid_rst_sum", int'(bus.out_sum), 0);
    checkOutput("mid_rst_ovf", int'(bus.overflow), 0);
    for (int i = 0; i < N; i++) vals[i] = i + 1;
    sendFrame(vals, -1);
    checkResult("post_rst", 15, 14, 120);
    checkOutput("post_rst_ovf", int'(bus.overflow), 0);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
